// File: rtl/alu_self_test.sv
// alu_self_test: LFSR-driven ALU regression sequencer comparing registered R0 against R0_verify.
// Define STOP_ON_FAIL_EN to halt on the first mismatch with the failing vector frozen on a/b/c_in/ALOP.
module alu_self_test #(
  parameter int          W       = 32,
  parameter int          NUM_VEC = 64,
  parameter int          LAT     = 1,
  parameter logic [31:0] SEED    = 32'h0000_0001,
  parameter int          CW      = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [W-1:0]  r0,
  input  logic [W-1:0]  r0_verify,
  output logic [W-1:0]  a,
  output logic [W-1:0]  b,
  output logic          c_in,
  output logic [2:0]    ALOP,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [CW-1:0] err_count,
  output logic [CW-1:0] vec_count
);
  typedef enum logic [2:0] {IDLE, DRIVE, WAIT, CHECK, DONE} state_t;
  localparam logic [31:0]   MASK  = 32'h8020_0003;
  localparam logic [31:0]   SEED0 = (SEED == 32'd0) ? 32'd1 : SEED;
  localparam logic [CW-1:0] TOTAL = CW'(8 * NUM_VEC);
  localparam int            LW    = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [LW-1:0] LAST  = LW'(LAT - 1);
  function automatic logic [31:0] step(input logic [31:0] l);
    return (l >> 1) ^ (l[0] ? MASK : 32'd0);
  endfunction
  // Truncates for W<32, zero-extends for W>32.
  function automatic logic [W-1:0] fit(input logic [31:0] x);
    return W'(x);
  endfunction
  state_t        state, state_n;
  logic [31:0]   lfsr, lfsr_n;
  logic [2:0]    op, op_n;
  logic [LW-1:0] cnt, cnt_n;
  logic [W-1:0]  a_n, b_n;
  logic          c_in_n, busy_n, done_n, pass_n;
  logic [2:0]    alop_n;
  logic [CW-1:0] err_n, vec_n, err_inc;
  logic          mismatch, stop;
  always_comb begin
    state_n  = state;
    lfsr_n   = lfsr;
    op_n     = op;
    cnt_n    = cnt;
    a_n      = a;
    b_n      = b;
    c_in_n   = c_in;
    alop_n   = ALOP;
    busy_n   = busy;
    done_n   = done;
    pass_n   = pass;
    err_n    = err_count;
    vec_n    = vec_count;
    mismatch = r0 != r0_verify;
    err_inc  = &err_count ? err_count : err_count + 1'b1;
`ifdef STOP_ON_FAIL_EN
    stop     = mismatch;
`else
    stop     = 1'b0;
`endif
    case (state)
      IDLE, DONE: if (start) begin
        state_n = DRIVE;
        lfsr_n  = SEED0;
        op_n    = 3'd0;
        err_n   = '0;
        vec_n   = '0;
        done_n  = 1'b0;
        pass_n  = 1'b0;
        busy_n  = 1'b1;
      end
      DRIVE: begin
        a_n     = fit(lfsr);
        b_n     = fit(step(lfsr));
        c_in_n  = lfsr[0];
        alop_n  = op;
        op_n    = op + 3'd1;
        lfsr_n  = (op == 3'd7) ? step(step(lfsr)) : lfsr;
        cnt_n   = '0;
        state_n = WAIT;
      end
      WAIT: begin
        cnt_n   = cnt + 1'b1;
        state_n = (cnt == LAST) ? CHECK : WAIT;
      end
      CHECK: begin
        err_n = mismatch ? err_inc : err_count;
        vec_n = vec_count + 1'b1;
        if (stop || vec_n == TOTAL) begin
          state_n = DONE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          pass_n  = err_n == '0;
        end else
          state_n = DRIVE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      lfsr      <= SEED0;
      op        <= 3'd0;
      cnt       <= '0;
      a         <= '0;
      b         <= '0;
      c_in      <= 1'b0;
      ALOP      <= 3'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      vec_count <= '0;
    end else begin
      state     <= state_n;
      lfsr      <= lfsr_n;
      op        <= op_n;
      cnt       <= cnt_n;
      a         <= a_n;
      b         <= b_n;
      c_in      <= c_in_n;
      ALOP      <= alop_n;
      busy      <= busy_n;
      done      <= done_n;
      pass      <= pass_n;
      err_count <= err_n;
      vec_count <= vec_n;
    end
endmodule

// File: tb/tb_alu_self_test.sv
// tb_alu_self_test: scoreboard bench for alu_self_test with a toy registered ALU and mismatch injection.
module tb_alu_self_test;
  localparam int W = 32, NV = 2, LAT = 1, CW = 16, TOT = 8 * NV;
  typedef struct packed {logic [31:0] a, b; logic c; logic [2:0] op;} vec_t;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [W-1:0] r0, r0_verify, a, b;
  logic c_in, busy, done, pass;
  logic [2:0] ALOP;
  logic [CW-1:0] err_count, vec_count;
  int checks = 0, errors = 0, inj = 0;
  vec_t q[$];
  alu_self_test #(.W(W), .NUM_VEC(NV), .LAT(LAT), .SEED(32'h0000_0001), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .r0(r0), .r0_verify(r0_verify),
    .a(a), .b(b), .c_in(c_in), .ALOP(ALOP), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .vec_count(vec_count));
  always #5 clk = ~clk;
  always @(posedge clk) r0 <= (a ^ {b[28:0], ALOP}) + W'(c_in);
  assign r0_verify = ((inj == 1 && ALOP == 3'd3) || (inj == 2 && a == 32'd1 && ALOP == 3'd3)) ? ~r0 : r0;
  function automatic logic [31:0] nxt(input logic [31:0] x);
    return {1'b0, x[31:1]} ^ (x[0] ? 32'h8020_0003 : 32'h0);
  endfunction
  task automatic run_vectors(input bit hold, input int nexp);
    vec_t e;
    logic [31:0] l = 32'd1;
    int c = 0, nb = 0;
    q.delete();
    for (int k = 0; k < TOT; k++) begin
      q.push_back('{a: l, b: nxt(l), c: l[0], op: 3'(k % 8)});
      if (k % 8 == 7) l = nxt(nxt(l));
    end
    @(negedge clk) start = 1'b1;
    do begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      nb += int'(busy);
      if (c % 3 == 1 && c / 3 < nexp) begin
        e = q.pop_front();
        checks++;
        if ({a, b, c_in, ALOP} !== e || vec_count !== CW'(c / 3)) begin
          errors++;
          $display("FAIL vector%0d: got a=%h b=%h c_in=%b ALOP=%0d vec=%0d want a=%h b=%h c_in=%b ALOP=%0d vec=%0d",
                   c / 3, a, b, c_in, ALOP, vec_count, e.a, e.b, e.c, e.op, c / 3);
        end
      end
      if (c == 1) begin
        checks++;
        if (a !== 32'h0000_0001 || b !== 32'h8020_0003 || c_in !== 1'b1) begin
          errors++;
          $display("FAIL first_vec: got a=%h b=%h c_in=%b want 00000001 80200003 1", a, b, c_in);
        end
      end
      if (c == 25 && nexp > 8) begin
        checks++;
        if (a !== 32'hC030_0002 || b !== 32'h6018_0001) begin
          errors++;
          $display("FAIL ninth_vec: got a=%h b=%h want c0300002 60180001", a, b);
        end
      end
      c++;
    end while (!done && c < 400);
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || nb != 3 * nexp) begin
      errors++;
      $display("FAIL run_length: got done=%b busy_cycles=%0d want 1 %0d", done, nb, 3 * nexp);
    end
  endtask
  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if ({a, b, c_in, ALOP, busy, done, pass, err_count, vec_count} !== '0) begin
      errors++;
      $display("FAIL reset: got a=%h b=%h ALOP=%0d busy=%b done=%b err=%0d vec=%0d want all 0",
               a, b, ALOP, busy, done, err_count, vec_count);
    end
    rst_n = 1'b1;
  endtask
  task automatic test_full_run;
    inj = 0;
    run_vectors(1'b0, TOT);
    checks++;
    if (pass !== 1'b1 || err_count !== 0 || vec_count !== CW'(TOT) || busy !== 1'b0) begin
      errors++;
      $display("FAIL full_run: got pass=%b err=%0d vec=%0d busy=%b want 1 0 %0d 0", pass, err_count, vec_count, busy, TOT);
    end
  endtask
  task automatic test_inject_op3;
    inj = 1;
    run_vectors(1'b0, TOT);
    checks++;
    if (pass !== 1'b0 || err_count !== CW'(NV) || vec_count !== CW'(TOT)) begin
      errors++;
      $display("FAIL inject_op3: got pass=%b err=%0d vec=%0d want 0 %0d %0d", pass, err_count, vec_count, NV, TOT);
    end
    inj = 0;
  endtask
  task automatic test_restart_from_done;
    run_vectors(1'b0, TOT);
    checks++;
    if (pass !== 1'b1 || err_count !== 0 || vec_count !== CW'(TOT)) begin
      errors++;
      $display("FAIL restart: got pass=%b err=%0d vec=%0d want 1 0 %0d", pass, err_count, vec_count, TOT);
    end
  endtask
  task automatic test_start_held;
    run_vectors(1'b1, TOT);
    repeat (3) @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || vec_count !== CW'(TOT) || pass !== 1'b1) begin
      errors++;
      $display("FAIL start_held: got done=%b busy=%b vec=%0d pass=%b want 1 0 %0d 1", done, busy, vec_count, pass, TOT);
    end
  endtask
  task automatic test_reset_mid_run;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (13) @(negedge clk);
    checks++;
    if (vec_count !== 16'd4 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_run_pos: got vec=%0d busy=%b want 4 1", vec_count, busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({a, b, c_in, ALOP, busy, done, pass, err_count, vec_count} !== '0) begin
      errors++;
      $display("FAIL mid_run_reset: got a=%h ALOP=%0d busy=%b done=%b vec=%0d want all 0", a, ALOP, busy, done, vec_count);
    end
    @(negedge clk) rst_n = 1'b1;
    run_vectors(1'b0, TOT);
    checks++;
    if (pass !== 1'b1 || vec_count !== CW'(TOT)) begin
      errors++;
      $display("FAIL post_reset_run: got pass=%b vec=%0d want 1 %0d", pass, vec_count, TOT);
    end
  endtask
  task automatic test_stop_on_fail;
    inj = 2;
`ifdef STOP_ON_FAIL_EN
    run_vectors(1'b0, 4);
    checks++;
    if (pass !== 1'b0 || err_count !== 16'd1 || vec_count !== 16'd4 || ALOP !== 3'd3 || a !== 32'd1) begin
      errors++;
      $display("FAIL stop_on_fail: got pass=%b err=%0d vec=%0d ALOP=%0d a=%h want 0 1 4 3 1", pass, err_count, vec_count, ALOP, a);
    end
`else
    run_vectors(1'b0, TOT);
    checks++;
    if (pass !== 1'b0 || err_count !== 16'd1 || vec_count !== CW'(TOT)) begin
      errors++;
      $display("FAIL single_miss: got pass=%b err=%0d vec=%0d want 0 1 %0d", pass, err_count, vec_count, TOT);
    end
`endif
    inj = 0;
  endtask
  initial begin
    test_reset;
    test_full_run;
    test_inject_op3;
    test_restart_from_done;
    test_start_held;
    test_reset_mid_run;
    test_stop_on_fail;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_self_test.md
Name: alu_self_test

Overview:
- Self-checking stimulus sequencer that sits directly upstream of the ALU top level.
- Drives a, b, c_in and ALOP into the ALU top level from a pseudo-random operand generator, sweeping all 8 opcodes per operand pair.
- Reads back the registered ALU result (R0) and the registered verification result (R0_verify), compares them, and reports mismatch count and overall pass/fail.
- Gives the ALU datapath a one-button on-board regression.

Parameters:
- W, 32: operand/result width; must match the ALU top level.
- NUM_VEC, 64: number of operand pairs; total vectors = 8*NUM_VEC.
- LAT, 1: clock edges from operand drive to a valid R0/R0_verify; minimum 1.
- SEED, 32'h0000_0001: LFSR start value; a zero seed is forced to 1.
- CW, 16: width of vec_count and err_count.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  run request; sampled only in IDLE or DONE
- r0  in  W  registered ALU result (R0)
- r0_verify  in  W  registered verification result (R0_verify)
- a  out  W  operand A to the ALU top level, registered
- b  out  W  operand B to the ALU top level, registered
- c_in  out  1  carry-in to the ALU top level, registered
- ALOP  out  3  opcode to the ALU top level, registered
- busy  out  1  run in progress
- done  out  1  run finished; held until the next start
- pass  out  1  valid only when done=1; set when err_count==0
- err_count  out  CW  mismatch count, saturates at all-ones
- vec_count  out  CW  number of vectors checked

Behaviour:
- Reset (async, rst_n=0): a=0, b=0, c_in=0, ALOP=0, busy=0, done=0, pass=0, err_count=0, vec_count=0, LFSR=SEED (1 if SEED==0), FSM=IDLE.
- LFSR: 32-bit right-shift Galois, mask 32'h8020_0003. step(L) = (L>>1) ^ (L[0] ? mask : 0).
  - W<32: operands use the low W bits.
  - W>32: operands are zero-extended.
- FSM states: IDLE, DRIVE, WAIT, CHECK, DONE.
- IDLE: on start=1, reload LFSR=SEED, clear err_count, vec_count, done and pass, set busy=1, go to DRIVE.
- DRIVE (1 cycle): on the clock edge, register the vector:
  - a<=L, b<=step(L), c_in<=L[0], ALOP<=op.
  - op increments 0..7 and wraps.
  - When op wraps 7->0, LFSR<=step(step(L)), so each operand pair is exercised under all 8 opcodes.
  - Go to WAIT.
- WAIT: stay for LAT cycles, counted by an internal counter, then go to CHECK.
- CHECK (1 cycle): compare r0 against r0_verify over the full W bits.
  - On mismatch, err_count++ (saturating).
  - vec_count++.
  - If vec_count reaches 8*NUM_VEC, go to DONE; otherwise go to DRIVE.
- Vector period is LAT+2 cycles. A full run is 8*NUM_VEC*(LAT+2) cycles from the DRIVE entry.
- DONE: busy=0, done=1, pass=(err_count==0).
  - a, b, c_in and ALOP hold their last values.
  - start=1 restarts the run exactly as from IDLE.
- start while busy=1 is ignored; no restart and no effect on counts.
- Reset asserted mid-run aborts immediately to the reset values. No partial results are retained.
- err_count saturation: a count already at all-ones stays there on further mismatches. pass remains 0.

Optional Feature:
- Macro STOP_ON_FAIL_EN.
- When defined: the first mismatch in CHECK sets err_count=1 and increments vec_count, then goes straight to DONE with pass=0. a, b, c_in and ALOP stay frozen at the failing vector for debug.
- When undefined: the run always completes all 8*NUM_VEC vectors.

Test Plan:
- NUM_VEC=2, LAT=1, r0_verify tied to r0, pulse start -> busy for 48 cycles, then done=1, pass=1, err_count=0, vec_count=16.
- SEED=1, first DRIVE -> a=32'h0000_0001, b=32'h8020_0003, c_in=1; ALOP steps 0..7 over 8 vectors with a and b unchanged; the 9th vector uses a=step(step(1)).
- NUM_VEC=4, bench forces r0_verify=~r0 whenever ALOP==3 -> done, err_count=4, pass=0, vec_count=32.
- rst_n pulled low during vector 5 -> all outputs 0 within the same cycle and busy=0; a new start restarts at a=32'h0000_0001, vec_count counting from 0.
- start held high for the whole run -> exactly one run; start while in DONE -> second run with counters cleared.
- STOP_ON_FAIL_EN defined, mismatch injected on vector index 3 -> done at the 4th CHECK, err_count=1, vec_count=4, ALOP=3 held.
